spi_reg_ctrl: RTL and testbench
===============================

Name: spi_reg_ctrl

Overview:
Register-bank controller between the SPI frame receiver and the PWM/output stage. Accepts complete 16-bit frames over a valid/ready handshake, then decodes and validates each one. Valid frames update the output-enable and PWM-enable registers immediately; duty-cycle writes are staged and committed glitch-free at a PWM period boundary. Malformed frames are dropped and counted.

Parameters:
MAX_ADDR, 4, highest legal register address
SYNC_DUTY, 1, 1 = duty staged until period boundary; 0 = duty applied like other registers
COMMIT_TIMEOUT, 1024, cycles a staged duty waits before forced commit; 0 disables the timeout
ERR_W, 8, width of the error counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
frame_valid  in  1  frame_data holds a complete frame
frame_data  in  16  [15]=write bit (1=write), [14:8]=address, [7:0]=data
frame_ready  out  1  controller can accept a frame this cycle
pwm_period_end  in  1  one-cycle pulse at PWM counter wrap
en_out_lo  out  8  address 0, output enables 7:0
en_out_hi  out  8  address 1, output enables 15:8
en_pwm_lo  out  8  address 2, PWM enables 7:0
en_pwm_hi  out  8  address 3, PWM enables 15:8
pwm_duty  out  8  address 4, active duty cycle
duty_pending  out  1  staged duty is waiting for commit
err_count  out  ERR_W  count of dropped frames, saturating

Behaviour:
- Reset: all register outputs 0, duty_pending 0, err_count 0, state IDLE, frame_ready 1, timer 0. Reset is asynchronous and may arrive mid-operation. Any captured frame is discarded.
- FSM has two states:
  - IDLE: frame_ready=1. When frame_valid&&frame_ready at edge T, frame_data is latched into hold_q and the FSM moves to DECODE.
  - DECODE: frame_ready=0. At edge T+1 the frame is decoded and the FSM returns to IDLE.
  - Maximum throughput is one frame per 2 cycles. frame_valid while not ready is ignored; the source holds it.
- Decode rules:
  - Frame is invalid if hold_q[15]=0 or hold_q[14:8]>MAX_ADDR. An invalid frame writes no register and increments err_count, which saturates at all-ones.
  - Address 0..3: the target register is written at edge T+1 and is visible from cycle T+2.
  - Address 4 with SYNC_DUTY=0: pwm_duty is written at edge T+1.
  - Address 4 with SYNC_DUTY=1: duty_shadow is written and duty_pending is set at edge T+1. The commit timer is cleared.
- Commit (SYNC_DUTY=1):
  - On any edge with duty_pending && (pwm_period_end || timer==COMMIT_TIMEOUT-1), pwm_duty<=duty_shadow, duty_pending<=0, and the timer clears.
  - The timer increments each cycle while duty_pending=1 and is held at 0 otherwise. It is unused when COMMIT_TIMEOUT=0.
- Simultaneous events:
  - Duty decode and commit on the same edge: commit uses the old shadow; the shadow takes the new value; duty_pending stays 1 (set wins over clear); the timer restarts.
  - Second duty write while pending: the shadow is overwritten (last writer wins); pending stays 1; the timer restarts.
  - pwm_period_end with duty_pending=0: no effect.
- Register writes never stall on commit. The handshake depends only on FSM state.

Decomposition:
- Package spi_regmap_pkg holds:
  - address constants ADDR_EN_OUT_LO=0, ADDR_EN_OUT_HI=1, ADDR_EN_PWM_LO=2, ADDR_EN_PWM_HI=3, ADDR_PWM_DUTY=4;
  - frame field positions FRM_WR_BIT=15, FRM_ADDR_MSB=14, FRM_ADDR_LSB=8, FRM_DATA_MSB=7;
  - FSM state encoding ST_IDLE, ST_DECODE.
- One sub-module, spi_duty_commit, holds duty_shadow, duty_pending, pwm_duty and the timeout counter. Its inputs are stage_en, stage_data and pwm_period_end.

Test Plan:
- Reset release, then frame 0x8055 -> en_out_lo=0x55 at cycle T+2; frame_ready low exactly at T+1; all other outputs 0.
- SYNC_DUTY=1, frame 0x84A0, pwm_period_end pulsed 20 cycles later -> pwm_duty stays 0x00 with duty_pending=1 until that edge, then pwm_duty=0xA0 and duty_pending=0.
- Frame 0x0512 (write bit 0), then 0x8533 (address 5) -> no register changes, err_count=2; with ERR_W=8, 300 bad frames -> err_count=255.
- Duty frame 0x8410 decoded on the same edge as pwm_period_end, with shadow=0x20 pending -> pwm_duty=0x20, shadow=0x10, duty_pending=1; next pulse -> pwm_duty=0x10.
- COMMIT_TIMEOUT=16, frame 0x8477, no period pulses -> pwm_duty=0x77 exactly 16 cycles after the shadow write; frame_valid held high continuously -> accepts every 2nd cycle.
- rst_n asserted in DECODE holding frame 0x83FF -> en_pwm_hi stays 0x00 after release and frame_ready=1 in the first cycle after reset.

Source files
------------

// File: rtl/spi_regmap_pkg.sv
// Shared register map, frame layout and FSM encoding for the SPI register controller.
// Frame layout: [15]=write bit, [14:8]=address, [7:0]=data.
package spi_regmap_pkg;

    localparam logic [6:0] ADDR_EN_OUT_LO = 7'd0;
    localparam logic [6:0] ADDR_EN_OUT_HI = 7'd1;
    localparam logic [6:0] ADDR_EN_PWM_LO = 7'd2;
    localparam logic [6:0] ADDR_EN_PWM_HI = 7'd3;
    localparam logic [6:0] ADDR_PWM_DUTY  = 7'd4;

    localparam int FRM_WR_BIT   = 15;
    localparam int FRM_ADDR_MSB = 14;
    localparam int FRM_ADDR_LSB = 8;
    localparam int FRM_DATA_MSB = 7;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_DECODE = 1'b1
    } state_t;

    // A frame is accepted only if it is a write to an address inside the map.
    function automatic logic frame_ok(input logic [15:0] f, input int unsigned max_addr);
        logic [31:0] addr;
        addr = {25'd0, f[FRM_ADDR_MSB:FRM_ADDR_LSB]};
        return f[FRM_WR_BIT] && (addr <= max_addr);
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// Frame handshake between the SPI frame receiver (master) and the register controller (slave).
interface spi_reg_ctrl_if;
    // A frame transfers on a clock edge where frame_valid && frame_ready are both high.
    // The source holds frame_valid/frame_data stable until that edge; frame_ready never
    // depends combinationally on frame_valid.
    logic        frame_valid;
    logic [15:0] frame_data;
    logic        frame_ready;

    modport master (
        output frame_valid,
        output frame_data,
        input  frame_ready
    );

    modport slave (
        input  frame_valid,
        input  frame_data,
        output frame_ready
    );
endinterface

// File: rtl/spi_duty_commit.sv
// Duty-cycle staging: holds the shadow duty value and commits it to the PWM stage
// on a period boundary or when the commit timeout expires.
module spi_duty_commit #(
    parameter int unsigned SYNC_DUTY      = 1,
    parameter int unsigned COMMIT_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       stage_en,
    input  logic [7:0] stage_data,
    input  logic       pwm_period_end,
    output logic [7:0] pwm_duty,
    output logic       duty_pending
);

    localparam int unsigned TMR_W    = (COMMIT_TIMEOUT > 1) ? $clog2(COMMIT_TIMEOUT) : 1;
    localparam int unsigned TMO_LAST = (COMMIT_TIMEOUT == 0) ? 0 : COMMIT_TIMEOUT - 1;

    logic [7:0]       duty_shadow;
    logic [TMR_W-1:0] timer;
    logic             timeout_hit;
    logic             commit;

    assign timeout_hit = (COMMIT_TIMEOUT != 0) && (timer == TMR_W'(TMO_LAST));
    assign commit      = duty_pending && (pwm_period_end || timeout_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_duty     <= '0;
            duty_shadow  <= '0;
            duty_pending <= 1'b0;
            timer        <= '0;
        end else if (SYNC_DUTY == 0) begin
            if (stage_en) pwm_duty <= stage_data;
            duty_pending <= 1'b0;
            timer        <= '0;
        end else begin
            // Commit always takes the shadow value from before this edge.
            if (commit) pwm_duty <= duty_shadow;
            // A new stage wins over the commit's clear: pending stays set, timer restarts.
            if (stage_en) begin
                duty_shadow  <= stage_data;
                duty_pending <= 1'b1;
                timer        <= '0;
            end else if (commit) begin
                duty_pending <= 1'b0;
                timer        <= '0;
            end else if (duty_pending) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: rtl/spi_reg_ctrl.sv
// Register-bank controller: accepts 16-bit SPI frames, validates and decodes them into
// enable registers, stages duty writes and counts dropped frames.
module spi_reg_ctrl
    import spi_regmap_pkg::*;
#(
    parameter int unsigned MAX_ADDR       = 4,
    parameter int unsigned SYNC_DUTY      = 1,
    parameter int unsigned COMMIT_TIMEOUT = 1024,
    parameter int unsigned ERR_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_reg_ctrl_if.slave    frame,
    input  logic             pwm_period_end,
    output logic [7:0]       en_out_lo,
    output logic [7:0]       en_out_hi,
    output logic [7:0]       en_pwm_lo,
    output logic [7:0]       en_pwm_hi,
    output logic [7:0]       pwm_duty,
    output logic             duty_pending,
    output logic [ERR_W-1:0] err_count,
    output state_t           fsm_state
);

    state_t      state;
    logic        ready_q;
    logic [15:0] hold_q;
    logic [6:0]  hold_addr;
    logic [7:0]  hold_data;
    logic        hold_ok;
    logic        stage_en;

    assign hold_addr = hold_q[FRM_ADDR_MSB:FRM_ADDR_LSB];
    assign hold_data = hold_q[FRM_DATA_MSB:0];
    assign hold_ok   = frame_ok(hold_q, MAX_ADDR);
    assign stage_en  = (state == ST_DECODE) && hold_ok && (hold_addr == ADDR_PWM_DUTY);

    assign frame.frame_ready = ready_q;
    assign fsm_state         = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            ready_q   <= 1'b1;
            hold_q    <= '0;
            en_out_lo <= '0;
            en_out_hi <= '0;
            en_pwm_lo <= '0;
            en_pwm_hi <= '0;
            err_count <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame.frame_valid && ready_q) begin
                        hold_q  <= frame.frame_data;
                        ready_q <= 1'b0;
                        state   <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                    if (hold_ok) begin
                        // The duty address is handled by the commit block via stage_en.
                        case (hold_addr)
                            ADDR_EN_OUT_LO: en_out_lo <= hold_data;
                            ADDR_EN_OUT_HI: en_out_hi <= hold_data;
                            ADDR_EN_PWM_LO: en_pwm_lo <= hold_data;
                            ADDR_EN_PWM_HI: en_pwm_hi <= hold_data;
                            default: ;
                        endcase
                    end else if (err_count != {ERR_W{1'b1}}) begin
                        err_count <= err_count + 1'b1;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    spi_duty_commit #(
        .SYNC_DUTY      (SYNC_DUTY),
        .COMMIT_TIMEOUT (COMMIT_TIMEOUT)
    ) u_duty_commit (
        .clk            (clk),
        .rst_n          (rst_n),
        .stage_en       (stage_en),
        .stage_data     (hold_data),
        .pwm_period_end (pwm_period_end),
        .pwm_duty       (pwm_duty),
        .duty_pending   (duty_pending)
    );

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: a default instance (timeout 1024) and a short-timeout
// instance (timeout 16) share clock and reset.
module tb_spi_reg_ctrl;
    import spi_regmap_pkg::*;

    logic clk;
    logic rst_n;
    logic pend_a_pulse;
    logic pend_b_pulse;

    spi_reg_ctrl_if if_a ();
    spi_reg_ctrl_if if_b ();

    logic [7:0] a_lo, a_hi, a_plo, a_phi, a_duty, a_err;
    logic       a_pend;
    state_t     a_state;
    logic [7:0] b_lo, b_hi, b_plo, b_phi, b_duty, b_err;
    logic       b_pend;
    state_t     b_state;

    int n_checks = 0;
    int n_fail   = 0;

    spi_reg_ctrl dut_a (
        .clk(clk), .rst_n(rst_n), .frame(if_a.slave), .pwm_period_end(pend_a_pulse),
        .en_out_lo(a_lo), .en_out_hi(a_hi), .en_pwm_lo(a_plo), .en_pwm_hi(a_phi),
        .pwm_duty(a_duty), .duty_pending(a_pend), .err_count(a_err), .fsm_state(a_state)
    );

    spi_reg_ctrl #(.COMMIT_TIMEOUT(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame(if_b.slave), .pwm_period_end(pend_b_pulse),
        .en_out_lo(b_lo), .en_out_hi(b_hi), .en_pwm_lo(b_plo), .en_pwm_hi(b_phi),
        .pwm_duty(b_duty), .duty_pending(b_pend), .err_count(b_err), .fsm_state(b_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drivers; all are entered and left 1 time unit after a rising edge.
    task automatic send_frame(input int which, input logic [15:0] d, input bit pulse);
        int waited = 0;
        while (((which == 0) ? if_a.frame_ready : if_b.frame_ready) !== 1'b1 && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (waited >= 10) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_wait: frame_ready not seen within 10 cycles");
        end
        if (which == 0) begin if_a.frame_valid = 1'b1; if_a.frame_data = d; end
        else            begin if_b.frame_valid = 1'b1; if_b.frame_data = d; end
        @(posedge clk); #1;
        if_a.frame_valid = 1'b0;
        if_b.frame_valid = 1'b0;
        check("ready_low_t1", (which == 0) ? if_a.frame_ready : if_b.frame_ready, 0);
        if (pulse) begin
            if (which == 0) pend_a_pulse = 1'b1; else pend_b_pulse = 1'b1;
        end
        @(posedge clk); #1;
        pend_a_pulse = 1'b0;
        pend_b_pulse = 1'b0;
        check("ready_high_t2", (which == 0) ? if_a.frame_ready : if_b.frame_ready, 1);
    endtask

    task automatic pulse_a();
        pend_a_pulse = 1'b1;
        @(posedge clk); #1;
        pend_a_pulse = 1'b0;
    endtask

    typedef struct {
        logic [15:0] frame;
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [7:0]  plo;
        logic [7:0]  phi;
        logic [7:0]  err;
    } vec_t;

    vec_t       vecs[9];
    logic [15:0] tp_frames[5];

    initial begin
        vecs[0] = '{16'h8055, 8'h55, 8'h00, 8'h00, 8'h00, 8'd0};
        vecs[1] = '{16'h81AA, 8'h55, 8'hAA, 8'h00, 8'h00, 8'd0};
        vecs[2] = '{16'h820F, 8'h55, 8'hAA, 8'h0F, 8'h00, 8'd0};
        vecs[3] = '{16'h83F0, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'd0};
        vecs[4] = '{16'h0512, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'd1};
        vecs[5] = '{16'h8533, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'd2};
        vecs[6] = '{16'h80C3, 8'hC3, 8'hAA, 8'h0F, 8'hF0, 8'd2};
        vecs[7] = '{16'hFF00, 8'hC3, 8'hAA, 8'h0F, 8'hF0, 8'd3};
        vecs[8] = '{16'h0055, 8'hC3, 8'hAA, 8'h0F, 8'hF0, 8'd4};
        tp_frames[0] = 16'h8001;
        tp_frames[1] = 16'h8102;
        tp_frames[2] = 16'h8203;
        tp_frames[3] = 16'h8304;
        tp_frames[4] = 16'h8000;

        rst_n = 1'b0;
        pend_a_pulse = 1'b0;
        pend_b_pulse = 1'b0;
        if_a.frame_valid = 1'b0; if_a.frame_data = '0;
        if_b.frame_valid = 1'b0; if_b.frame_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        check("rst_ready", if_a.frame_ready, 1);
        check("rst_lo", a_lo, 0);
        check("rst_hi", a_hi, 0);
        check("rst_plo", a_plo, 0);
        check("rst_phi", a_phi, 0);
        check("rst_duty", a_duty, 0);
        check("rst_pend", a_pend, 0);
        check("rst_err", a_err, 0);
        check("rst_state", 32'(a_state), 32'(ST_IDLE));

        // table: register writes and dropped frames
        for (int i = 0; i < 9; i++) begin
            send_frame(0, vecs[i].frame, 1'b0);
            check("vec_lo", a_lo, vecs[i].lo);
            check("vec_hi", a_hi, vecs[i].hi);
            check("vec_plo", a_plo, vecs[i].plo);
            check("vec_phi", a_phi, vecs[i].phi);
            check("vec_err", a_err, vecs[i].err);
            check("vec_duty", a_duty, 0);
            check("vec_pend", a_pend, 0);
        end

        // staged duty waits for the period boundary
        send_frame(0, 16'h84A0, 1'b0);
        check("stage_pend", a_pend, 1);
        check("stage_duty", a_duty, 8'h00);
        for (int i = 0; i < 19; i++) begin
            @(posedge clk); #1;
            check("hold_duty", a_duty, 8'h00);
            check("hold_pend", a_pend, 1);
        end
        pulse_a();
        check("commit_duty", a_duty, 8'hA0);
        check("commit_pend", a_pend, 0);

        // duty decode coinciding with commit
        send_frame(0, 16'h8420, 1'b0);
        check("pre_sim_pend", a_pend, 1);
        send_frame(0, 16'h8410, 1'b1);
        check("sim_duty", a_duty, 8'h20);
        check("sim_pend", a_pend, 1);
        pulse_a();
        check("sim_next_duty", a_duty, 8'h10);
        check("sim_next_pend", a_pend, 0);
        pulse_a();
        check("idle_pulse_duty", a_duty, 8'h10);
        check("idle_pulse_pend", a_pend, 0);

        // last writer wins while pending
        send_frame(0, 16'h8411, 1'b0);
        send_frame(0, 16'h8412, 1'b0);
        check("lww_pend", a_pend, 1);
        check("lww_duty_old", a_duty, 8'h10);
        pulse_a();
        check("lww_duty", a_duty, 8'h12);
        check("lww_lo_kept", a_lo, 8'hC3);

        // error counter saturation
        for (int i = 0; i < 300; i++) send_frame(0, (i % 2 == 0) ? 16'h0512 : 16'h8533, 1'b0);
        check("sat_err", a_err, 8'hFF);
        check("sat_lo", a_lo, 8'hC3);
        check("sat_phi", a_phi, 8'hF0);
        check("sat_duty", a_duty, 8'h12);

        // back-to-back throughput with valid held high
        if_b.frame_valid = 1'b1;
        if_b.frame_data  = tp_frames[0];
        for (int k = 0; k < 8; k++) begin
            check("tp_ready", if_b.frame_ready, (k % 2 == 0) ? 1 : 0);
            @(posedge clk); #1;
            if (k % 2 == 0) if_b.frame_data = tp_frames[k / 2 + 1];
        end
        if_b.frame_valid = 1'b0;
        check("tp_lo", b_lo, 8'h01);
        check("tp_hi", b_hi, 8'h02);
        check("tp_plo", b_plo, 8'h03);
        check("tp_phi", b_phi, 8'h04);

        // forced commit after 16 cycles with no period pulses
        send_frame(1, 16'h8477, 1'b0);
        check("tmo_stage_pend", b_pend, 1);
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("tmo_hold_duty", b_duty, 8'h00);
            check("tmo_hold_pend", b_pend, 1);
        end
        @(posedge clk); #1;
        check("tmo_duty", b_duty, 8'h77);
        check("tmo_pend", b_pend, 0);

        // reset arriving while a frame sits in DECODE
        check("pre_rst_ready", if_a.frame_ready, 1);
        if_a.frame_valid = 1'b1;
        if_a.frame_data  = 16'h83FF;
        @(posedge clk); #1;
        check("pre_rst_state", 32'(a_state), 32'(ST_DECODE));
        rst_n = 1'b0;
        if_a.frame_valid = 1'b0;
        #1;
        check("async_rst_phi", a_phi, 8'h00);
        check("async_rst_ready", if_a.frame_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", if_a.frame_ready, 1);
        check("post_rst_state", 32'(a_state), 32'(ST_IDLE));
        check("post_rst_phi", a_phi, 8'h00);
        check("post_rst_err", a_err, 8'h00);
        check("post_rst_duty", a_duty, 8'h00);
        check("post_rst_b_lo", b_lo, 8'h00);
        @(posedge clk); #1;
        check("post_rst_phi2", a_phi, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
